// File: rtl/fifo_rd_checker_if.sv
// rtl/fifo_rd_checker_if.sv - read-side FIFO port bundle for the pattern checker
//
// Purpose: groups the async FIFO read port so the checker and the FIFO (or a
// bench model of it) connect through one bundle.
// Signals:
//   rinc    read strobe, driven by the consumer
//   rempty  FIFO empty flag, rclk-synchronous, driven by the FIFO
//   rdata   FIFO head word, valid whenever rempty is low, driven by the FIFO
// Modports:
//   master  consumer side (drives rinc)
//   slave   FIFO side (drives rempty/rdata)

interface fifo_rd_checker_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  rinc;
  logic                  rempty;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output rinc,
    input  rempty,
    input  rdata
  );

  modport slave (
    input  rinc,
    output rempty,
    output rdata
  );
endinterface

// File: rtl/fifo_rd_checker.sv
// rtl/fifo_rd_checker.sv - read-side consumer/checker for the async FIFO
//
// Purpose: pops the async FIFO in the rclk domain with a programmable
// burst/gap throttle and checks that the data follows the incrementing
// 0,1,2,... pattern of the write-side generator. Read/error counters and a
// capture of the first mismatch are exposed for ILA probing.
// Optional feature: define FIFO_RD_WDOG_EN to build a starvation watchdog
// (WDOG_CYCLES consecutive READ+empty cycles sets wdog_to). Without it,
// wdog_to is tied low; the port list is the same in both builds.
// Ports:
//   rclk       read-domain clock
//   rrst_n     asynchronous active-low reset
//   en         run enable (level)
//   burst_len  reads per burst, 0 = continuous
//   gap_len    idle cycles between bursts, 0 = no gap
//   fifo       FIFO read port bundle (rinc out, rempty/rdata in)
//   rd_cnt     accepted reads, wrapping
//   err_cnt    mismatches, saturating at 16'hFFFF
//   err        sticky, set on first mismatch
//   err_exp    expected value at the first mismatch
//   err_act    actual rdata at the first mismatch
//   busy       FSM not idle
//   wdog_to    sticky starvation timeout

module fifo_rd_checker #(
  parameter int DATA_WIDTH  = 32,
  parameter int CNT_WIDTH   = 32,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  en,
  input  logic [7:0]            burst_len,
  input  logic [7:0]            gap_len,
  fifo_rd_checker_if.master     fifo,
  output logic [CNT_WIDTH-1:0]  rd_cnt,
  output logic [15:0]           err_cnt,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] err_exp,
  output logic [DATA_WIDTH-1:0] err_act,
  output logic                  busy,
  output logic                  wdog_to
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            burst_q, burst_d;
  logic [7:0]            gap_q,   gap_d;
  logic [DATA_WIDTH-1:0] exp_q;
  logic                  rinc;
  logic                  burst_end;
  logic                  gap_end;

  // Combinational from rempty so a read is never issued to an empty FIFO.
  assign rinc      = (state_q == READ) && !fifo.rempty;
  assign fifo.rinc = rinc;
  assign busy      = (state_q != IDLE);

  // burst_len is sampled live; burst_len==0 means the burst never ends.
  assign burst_end = (burst_len != 8'd0) && (burst_q == burst_len - 8'd1);

  // Compare against gap_len with a widened sum so a live shrink of gap_len
  // below the running count ends the gap instead of waiting for a wrap.
  assign gap_end   = ({1'b0, gap_q} + 9'd1) >= {1'b0, gap_len};

  // ------------------------------------------------------------------
  // Throttle FSM
  // ------------------------------------------------------------------
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q <= IDLE;
      burst_q <= 8'd0;
      gap_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    gap_d   = gap_q;

    case (state_q)
      IDLE: begin
        burst_d = 8'd0;
        gap_d   = 8'd0;
        state_d = READ;
      end

      READ: begin
        if (rinc) begin
          if (burst_end) begin
            burst_d = 8'd0;
            if (gap_len != 8'd0) begin
              state_d = GAP;
            end
          end else begin
            burst_d = burst_q + 8'd1;
          end
        end
      end

      GAP: begin
        if (gap_end) begin
          gap_d   = 8'd0;
          state_d = READ;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Dropping en wins over every transition; a read on that edge still
    // lands in the datapath below because rinc is already high.
    if (!en) begin
      state_d = IDLE;
    end
  end

  // ------------------------------------------------------------------
  // Pattern check and counters
  // ------------------------------------------------------------------
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      exp_q   <= '0;
      rd_cnt  <= '0;
      err_cnt <= 16'd0;
      err     <= 1'b0;
      err_exp <= '0;
      err_act <= '0;
    end else if (rinc) begin
      rd_cnt <= rd_cnt + CNT_WIDTH'(1);
      if (fifo.rdata == exp_q) begin
        exp_q <= exp_q + DATA_WIDTH'(1);
      end else begin
        // Resync on the observed word so one dropped word is one error.
        exp_q <= fifo.rdata + DATA_WIDTH'(1);
        if (err_cnt != 16'hFFFF) begin
          err_cnt <= err_cnt + 16'd1;
        end
        if (!err) begin
          err     <= 1'b1;
          err_exp <= exp_q;
          err_act <= fifo.rdata;
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Starvation watchdog
  // ------------------------------------------------------------------
`ifdef FIFO_RD_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic [WDOG_W-1:0] wdog_cnt;
  logic              wdog_q;
  logic              starved;

  assign starved = (state_q == READ) && fifo.rempty;
  assign wdog_to = wdog_q;

  // Counter saturates at WDOG_CYCLES; the flag stays set until reset.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      wdog_cnt <= '0;
      wdog_q   <= 1'b0;
    end else if (!starved) begin
      wdog_cnt <= '0;
    end else if (wdog_cnt != WDOG_W'(WDOG_CYCLES)) begin
      wdog_cnt <= wdog_cnt + WDOG_W'(1);
      if (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1)) begin
        wdog_q <= 1'b1;
      end
    end
  end
`else
  logic unused_wdog;

  assign unused_wdog = ^WDOG_CYCLES;
  assign wdog_to     = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_checker.sv
// tb/tb_fifo_rd_checker.sv - directed bench for fifo_rd_checker with a queue-based FIFO model

module tb_fifo_rd_checker;

  localparam int DW = 8;

`ifdef FIFO_RD_WDOG_EN
  localparam logic [31:0] WDOG_EXP = 32'd1;
`else
  localparam logic [31:0] WDOG_EXP = 32'd0;
`endif

  logic          rclk = 1'b0;
  logic          rrst_n;
  logic          en;
  logic [7:0]    burst_len;
  logic [7:0]    gap_len;
  logic [31:0]   rd_cnt;
  logic [15:0]   err_cnt;
  logic          err;
  logic [DW-1:0] err_exp;
  logic [DW-1:0] err_act;
  logic          busy;
  logic          wdog_to;

  int checks = 0;
  int errors = 0;

  always #5 rclk = ~rclk;

  fifo_rd_checker_if #(.DATA_WIDTH(DW)) bus ();

  fifo_rd_checker #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (32),
    .WDOG_CYCLES(8)
  ) dut (
    .rclk     (rclk),
    .rrst_n   (rrst_n),
    .en       (en),
    .burst_len(burst_len),
    .gap_len  (gap_len),
    .fifo     (bus),
    .rd_cnt   (rd_cnt),
    .err_cnt  (err_cnt),
    .err      (err),
    .err_exp  (err_exp),
    .err_act  (err_act),
    .busy     (busy),
    .wdog_to  (wdog_to)
  );

  // FIFO model: pop on an accepted read, present the new head after negedge.
  logic [DW-1:0] q[$];
  logic          auto_fill = 1'b0;
  logic [DW-1:0] next_wr   = '0;
  int            pulses    = 0;
  logic [DW-1:0] popped;

  always @(posedge rclk) begin
    if (bus.rinc === 1'b1 && q.size() > 0) begin
      popped = q.pop_front();
      pulses++;
    end
  end

  always @(negedge rclk) begin
    if (auto_fill) begin
      while (q.size() < 4) begin
        q.push_back(next_wr);
        next_wr++;
      end
    end
    bus.rempty = (q.size() == 0);
    bus.rdata  = (q.size() > 0) ? q[0] : '0;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge rclk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  logic [DW-1:0] mm_words [6] = '{8'd0, 8'd1, 8'd2, 8'd5, 8'd6, 8'd7};

  initial begin
    rrst_n     = 1'b0;
    en         = 1'b0;
    burst_len  = 8'd0;
    gap_len    = 8'd0;
    bus.rempty = 1'b1;
    bus.rdata  = '0;
    step(2);

    // Reset state
    chk("rst_rinc",    32'(bus.rinc), 32'd0);
    chk("rst_busy",    32'(busy),     32'd0);
    chk("rst_rd_cnt",  rd_cnt,        32'd0);
    chk("rst_err_cnt", 32'(err_cnt),  32'd0);
    chk("rst_err",     32'(err),      32'd0);
    chk("rst_err_exp", 32'(err_exp),  32'd0);
    chk("rst_err_act", 32'(err_act),  32'd0);
    chk("rst_wdog",    32'(wdog_to),  32'd0);

    // Ordering: preloaded 0..15, continuous reads
    for (int i = 0; i < 16; i++) q.push_back(DW'(i));
    rrst_n = 1'b1;
    en     = 1'b1;
    step(25);
    chk("ord_pulses",  32'(pulses),   32'd16);
    chk("ord_rd_cnt",  rd_cnt,        32'd16);
    chk("ord_err",     32'(err),      32'd0);
    chk("ord_err_cnt", 32'(err_cnt),  32'd0);
    chk("ord_rinc_empty", 32'(bus.rinc), 32'd0);
    chk("ord_busy",    32'(busy),     32'd1);

    // Burst/gap: 4 reads, 3 idle, repeating
    en = 1'b0;
    step(1);
    chk("idle_busy", 32'(busy), 32'd0);
    burst_len = 8'd4;
    gap_len   = 8'd3;
    next_wr   = 8'd16;
    auto_fill = 1'b1;
    en        = 1'b1;
    step(1);
    for (int k = 0; k < 14; k++) begin
      chk($sformatf("bg_rinc_%0d", k), 32'(bus.rinc), ((k % 7) < 4) ? 32'd1 : 32'd0);
      chk($sformatf("bg_busy_%0d", k), 32'(busy), 32'd1);
      step(1);
    end
    chk("bg_rd_cnt", rd_cnt, 32'd24);

    // en dropped mid-burst: read on the dropping edge still counts
    step(1);
    chk("en_mid_rinc", 32'(bus.rinc), 32'd1);
    en = 1'b0;
    step(1);
    chk("en_off_busy",   32'(busy),     32'd0);
    chk("en_off_rinc",   32'(bus.rinc), 32'd0);
    chk("en_off_rd_cnt", rd_cnt,        32'd26);
    auto_fill = 1'b0;
    step(3);
    chk("en_hold_rd_cnt",  rd_cnt,       32'd26);
    chk("en_hold_err_cnt", 32'(err_cnt), 32'd0);
    chk("en_hold_busy",    32'(busy),    32'd0);

    // Asynchronous reset mid-burst
    burst_len = 8'd0;
    gap_len   = 8'd0;
    auto_fill = 1'b1;
    en        = 1'b1;
    step(3);
    chk("pre_rst_busy", 32'(busy),     32'd1);
    chk("pre_rst_rinc", 32'(bus.rinc), 32'd1);
    rrst_n = 1'b0;
    #1;
    chk("arst_rinc",    32'(bus.rinc), 32'd0);
    chk("arst_busy",    32'(busy),     32'd0);
    chk("arst_rd_cnt",  rd_cnt,        32'd0);
    chk("arst_err_cnt", 32'(err_cnt),  32'd0);
    chk("arst_err",     32'(err),      32'd0);
    en        = 1'b0;
    auto_fill = 1'b0;
    q.delete();
    next_wr = '0;
    step(2);
    rrst_n = 1'b1;
    step(1);

    // Single mismatch with resync
    foreach (mm_words[i]) q.push_back(mm_words[i]);
    en = 1'b1;
    step(10);
    chk("mm_rd_cnt",  rd_cnt,        32'd6);
    chk("mm_err_cnt", 32'(err_cnt),  32'd1);
    chk("mm_err",     32'(err),      32'd1);
    chk("mm_err_exp", 32'(err_exp),  32'd3);
    chk("mm_err_act", 32'(err_act),  32'd5);
    q.push_back(8'd8);
    step(3);
    chk("resync_err_cnt", 32'(err_cnt), 32'd1);
    chk("resync_rd_cnt",  rd_cnt,       32'd7);
    q.push_back(8'd20);
    step(3);
    chk("mm2_err_cnt", 32'(err_cnt), 32'd2);
    chk("mm2_err_exp", 32'(err_exp), 32'd3);
    chk("mm2_err_act", 32'(err_act), 32'd5);
    chk("mm2_rd_cnt",  rd_cnt,       32'd8);

    // Wrap-around: 0..255,0,1 on an 8-bit datapath
    en     = 1'b0;
    rrst_n = 1'b0;
    step(1);
    rrst_n = 1'b1;
    for (int i = 0; i < 258; i++) q.push_back(DW'(i));
    en = 1'b1;
    step(270);
    chk("wrap_rd_cnt",  rd_cnt,       32'd258);
    chk("wrap_err_cnt", 32'(err_cnt), 32'd0);
    chk("wrap_err",     32'(err),     32'd0);

    // Watchdog: starve the reader
    en     = 1'b0;
    rrst_n = 1'b0;
    step(1);
    rrst_n = 1'b1;
    en     = 1'b1;
    step(8);
    chk("wd_early",      32'(wdog_to),  32'd0);
    chk("wd_rinc_empty", 32'(bus.rinc), 32'd0);
    chk("wd_busy",       32'(busy),     32'd1);
    step(1);
    chk("wd_fire", 32'(wdog_to), WDOG_EXP);
    q.push_back(8'd0);
    q.push_back(8'd1);
    step(5);
    chk("wd_sticky", 32'(wdog_to), WDOG_EXP);
    chk("wd_rd_cnt", rd_cnt,       32'd2);
    chk("wd_err",    32'(err),     32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
